// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port, steers store lanes,
// extends load data, stalls the front of the pipe while an access is pending.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lsb;

  logic        w_is_mem, w_misalign, w_start, w_wb_en;
  logic [31:0] w_wdata, w_load;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_is_mem   = mem_read_in | mem_write_in;
  assign w_misalign = w_is_mem &
                      (((funct3_in[1:0] == 2'b01) & alu_result_in[0]) |
                       ((funct3_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00)));
  assign w_start    = (r_state == S_IDLE) & w_is_mem & ~w_misalign;

  always_comb begin
    w_wdata = store_data_in;
    w_wstrb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        w_wdata = {4{store_data_in[7:0]}};
        w_wstrb = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data_in[15:0]}};
        w_wstrb = 4'b0011 << alu_result_in[1:0];
      end
      default: ;
    endcase
  end

  // Lane select uses the latched offset; the word itself arrives with ack.
  assign w_byte = dmem_rdata[{r_lsb, 3'b000} +: 8];
  assign w_half = r_lsb[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_we     <= 1'b0;
      r_wstrb  <= 4'd0;
      r_funct3 <= 3'd0;
      r_lsb    <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt    <= 8'd0;
        r_addr   <= {alu_result_in[31:2], 2'b00};
        r_we     <= mem_write_in;
        r_wdata  <= w_wdata;
        r_wstrb  <= mem_write_in ? w_wstrb : 4'd0;
        r_funct3 <= funct3_in;
        r_lsb    <= alu_result_in[1:0];
      end else if (r_state == S_BUSY && !dmem_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    w_wb_en      = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    mem_data_out = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_misalign) begin
          misalign_err = 1'b1;
        end else if (w_is_mem) begin
          stall  = 1'b1;
          w_next = S_BUSY;
        end else begin
          w_wb_en = 1'b1;
        end
      end
      S_BUSY: begin
        dmem_req = 1'b1;
        // Ack wins over timeout when both land in the same cycle.
        if (dmem_ack) begin
          w_next  = S_IDLE;
          w_wb_en = 1'b1;
          if (!r_we) mem_data_out = w_load;
        end else if (r_cnt == LP_LAST) begin
          bus_err = 1'b1;
          w_next  = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
    endcase
    if (reset) begin
      stall        = 1'b0;
      dmem_req     = 1'b0;
      w_wb_en      = 1'b0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
      mem_data_out = 32'd0;
    end
  end

  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;
  assign alu_result_out = alu_result_in;
  assign rd_out         = rd_in;
  assign reg_write_out  = reg_write_in & w_wb_en;
  assign mem_to_reg_out = mem_to_reg_in & w_wb_en;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table with an expected-result queue,
// plus hand sequences for reset behaviour.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, store_data_in, dmem_rdata;
  logic [2:0]  funct3_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, dmem_ack;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, stall, reg_write_out, mem_to_reg_out;
  logic        misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .funct3_in(funct3_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        rd_en, wr_en;
    logic [31:0] alu, sdata, rdata;
    logic [4:0]  rd;
    logic        rw, m2r;
    int          ack_at;   // BUSY cycle (1-based) that gets ack; 0 = never
    logic [31:0] e_mem;
    logic        e_rw, e_mis, e_berr;
    int          e_stalls;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs[15];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] f3, input logic rd_en,
      input logic wr_en, input logic [31:0] alu, input logic [31:0] sdata,
      input logic [31:0] rdata, input logic [4:0] rd, input logic rw, input logic m2r,
      input int ack_at, input logic [31:0] e_mem, input logic e_rw, input logic e_mis,
      input logic e_berr, input int e_stalls, input logic e_req, input logic e_we,
      input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
    vec_t v;
    v.name = name; v.f3 = f3; v.rd_en = rd_en; v.wr_en = wr_en; v.alu = alu;
    v.sdata = sdata; v.rdata = rdata; v.rd = rd; v.rw = rw; v.m2r = m2r;
    v.ack_at = ack_at; v.e_mem = e_mem; v.e_rw = e_rw; v.e_mis = e_mis;
    v.e_berr = e_berr; v.e_stalls = e_stalls; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    return v;
  endfunction

  task automatic drive_nop();
    alu_result_in = 32'd0; store_data_in = 32'd0; funct3_in = 3'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; rd_in = 5'd0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Called at a falling edge; returns at the falling edge after the output cycle.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   busy, stalls;
    bit   seen, done;
    alu_result_in = v.alu; store_data_in = v.sdata; funct3_in = v.f3;
    mem_read_in = v.rd_en; mem_write_in = v.wr_en; rd_in = v.rd;
    reg_write_in = v.rw; mem_to_reg_in = v.m2r; dmem_ack = 1'b0; dmem_rdata = v.rdata;
    sb_q.push_back(v);
    busy = 0; stalls = 0; seen = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (dmem_req) begin
        busy++;
        if (!seen) begin
          seen = 1;
          chk({v.name, " addr"}, dmem_addr, v.e_addr);
          chk({v.name, " we"}, 32'(dmem_we), 32'(v.e_we));
          if (v.e_we) begin
            chk({v.name, " wdata"}, dmem_wdata, v.e_wdata);
            chk({v.name, " wstrb"}, 32'(dmem_wstrb), 32'(v.e_wstrb));
          end
        end
        if (busy == v.ack_at) begin
          dmem_ack = 1'b1;
          #1;
        end
      end
      if (!stall) begin
        done = 1;
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL %s scoreboard: got empty queue expected entry", v.name);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, " mem_data"}, mem_data_out, e.e_mem);
          chk({e.name, " reg_write"}, 32'(reg_write_out), 32'(e.e_rw));
          chk({e.name, " alu_out"}, alu_result_out, e.alu);
          chk({e.name, " rd_out"}, 32'(rd_out), 32'(e.rd));
          chk({e.name, " misalign"}, 32'(misalign_err), 32'(e.e_mis));
          chk({e.name, " bus_err"}, 32'(bus_err), 32'(e.e_berr));
          chk({e.name, " stalls"}, 32'(stalls), 32'(e.e_stalls));
          chk({e.name, " req_seen"}, 32'(seen), 32'(e.e_req));
        end
      end else begin
        stalls++;
        chk({v.name, " rw_in_stall"}, 32'(reg_write_out), 32'd0);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: got stall stuck expected release", v.name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name      f3     rd wr alu          sdata        rdata        rd    rw m2r ack  e_mem        rw mis be st req we addr         wdata        wstrb
    vecs[0]  = mk("add",    3'b000,0,0,32'h1234,    32'h0,       32'h0,       5'd5, 1,0, 0,   32'h0,       1, 0, 0, 0, 0, 0, 32'h0,       32'h0,       4'b0000);
    vecs[1]  = mk("lb",     3'b000,1,0,32'h103,     32'h0,       32'h80FF00AA,5'd7, 1,1, 2,   32'hFFFFFF80,1, 0, 0, 2, 1, 0, 32'h100,     32'h0,       4'b0000);
    vecs[2]  = mk("lbu",    3'b100,1,0,32'h103,     32'h0,       32'h80FF00AA,5'd7, 1,1, 2,   32'h00000080,1, 0, 0, 2, 1, 0, 32'h100,     32'h0,       4'b0000);
    vecs[3]  = mk("sh",     3'b001,0,1,32'h22,      32'hBEEF,    32'h0,       5'd0, 0,0, 3,   32'h0,       0, 0, 0, 3, 1, 1, 32'h20,      32'hBEEFBEEF,4'b1100);
    vecs[4]  = mk("lw_mis", 3'b010,1,0,32'h6,       32'h0,       32'h0,       5'd9, 1,1, 0,   32'h0,       0, 1, 0, 0, 0, 0, 32'h0,       32'h0,       4'b0000);
    vecs[5]  = mk("lw_tmo", 3'b010,1,0,32'h40,      32'h0,       32'h11111111,5'd10,1,1, 0,   32'h0,       0, 0, 1, 4, 1, 0, 32'h40,      32'h0,       4'b0000);
    vecs[6]  = mk("lw_ack4",3'b010,1,0,32'h40,      32'h0,       32'hDEADBEEF,5'd11,1,1, 4,   32'hDEADBEEF,1, 0, 0, 4, 1, 0, 32'h40,      32'h0,       4'b0000);
    vecs[7]  = mk("lh",     3'b001,1,0,32'h12,      32'h0,       32'h80017FFF,5'd12,1,1, 1,   32'hFFFF8001,1, 0, 0, 1, 1, 0, 32'h10,      32'h0,       4'b0000);
    vecs[8]  = mk("lhu",    3'b101,1,0,32'h12,      32'h0,       32'h80017FFF,5'd12,1,1, 1,   32'h00008001,1, 0, 0, 1, 1, 0, 32'h10,      32'h0,       4'b0000);
    vecs[9]  = mk("sb",     3'b000,0,1,32'h41,      32'h123456A5,32'h0,       5'd0, 0,0, 1,   32'h0,       0, 0, 0, 1, 1, 1, 32'h40,      32'hA5A5A5A5,4'b0010);
    vecs[10] = mk("sw",     3'b010,0,1,32'h80,      32'hCAFEF00D,32'h0,       5'd0, 0,0, 2,   32'h0,       0, 0, 0, 2, 1, 1, 32'h80,      32'hCAFEF00D,4'b1111);
    vecs[11] = mk("sh_mis", 3'b001,0,1,32'h23,      32'hBEEF,    32'h0,       5'd0, 0,0, 0,   32'h0,       0, 1, 0, 0, 0, 0, 32'h0,       32'h0,       4'b0000);
    vecs[12] = mk("lh_up",  3'b001,1,0,32'h2,       32'h0,       32'h12345678,5'd13,1,1, 1,   32'h00001234,1, 0, 0, 1, 1, 0, 32'h0,       32'h0,       4'b0000);
    vecs[13] = mk("rdwr",   3'b010,1,1,32'h10,      32'h11223344,32'h55555555,5'd14,0,0, 1,   32'h0,       0, 0, 0, 1, 1, 1, 32'h10,      32'h11223344,4'b1111);
    vecs[14] = mk("lb_b0",  3'b000,1,0,32'h200,     32'h0,       32'hFFFFFF7F,5'd15,1,1, 1,   32'h0000007F,1, 0, 0, 1, 1, 0, 32'h200,     32'h0,       4'b0000);

    drive_nop();
    reset = 1'b1;
    alu_result_in = 32'h40; funct3_in = 3'b010; mem_read_in = 1'b1; reg_write_in = 1'b1;
    #2;
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst reg_write", 32'(reg_write_out), 32'd0);
    chk("rst mem_data", mem_data_out, 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    chk("rst dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    alu_result_in = 32'h6;
    #1;
    chk("rst misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    chk("rst req after edge", 32'(dmem_req), 32'd0);
    reset = 1'b0;
    drive_nop();
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of an access, then an ack that arrives too late.
    alu_result_in = 32'h40; funct3_in = 3'b010; mem_read_in = 1'b1;
    reg_write_in = 1'b1; mem_to_reg_in = 1'b1; rd_in = 5'd3;
    @(negedge clk);
    #1;
    chk("midrst req before", 32'(dmem_req), 32'd1);
    chk("midrst stall before", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst req async", 32'(dmem_req), 32'd0);
    chk("midrst stall async", 32'(stall), 32'd0);
    chk("midrst rw async", 32'(reg_write_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("late ack rw", 32'(reg_write_out), 32'd0);
    chk("late ack mem_data", mem_data_out, 32'd0);
    chk("late ack req", 32'(dmem_req), 32'd0);
    #1;
    drive_nop();
    @(negedge clk);
    #1;
    chk("after late ack req", 32'(dmem_req), 32'd0);
    chk("after late ack stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
